// File: rtl/matrix_operand_dma.sv
// matrix_operand_dma: fetches two operand words from main memory, hands them to the
// execution unit, then writes the returned result back to main memory.
module matrix_operand_dma #(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned ADDR_W    = 16,
  parameter logic [3:0]  MEM_SEL   = 4'h0,
  parameter int unsigned MEM_DEPTH = 12
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [11:0]       cmd_src0,
  input  logic [11:0]       cmd_src1,
  input  logic [11:0]       cmd_dst,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_nRead,
  output logic              mem_nWrite,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IdxW = 12;

  typedef enum logic [2:0] {
    StIdle, StRd0, StRd1, StCap, StIssue, StWaitRes, StWr, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     src1_q, dst_q;
  logic                err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   op_a_q, op_b_q, wdata_q;
  logic                cmd_bad;

  // Any out-of-range index rejects the whole command before touching the bus.
  assign cmd_bad = (cmd_src0 >= IdxW'(MEM_DEPTH)) || (cmd_src1 >= IdxW'(MEM_DEPTH)) ||
                   (cmd_dst >= IdxW'(MEM_DEPTH));

  // State register.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (cmd_valid) state_d = cmd_bad ? StDone : StRd0;
      StRd0:     state_d = StRd1;
      StRd1:     state_d = StCap;
      StCap:     state_d = StIssue;
      StIssue:   if (op_ready) state_d = StWaitRes;
      StWaitRes: if (res_valid) state_d = StWr;
      StWr:      state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Command, address and data capture; the address register is loaded on the edge that
  // enters each bus state, so it holds its last value whenever the strobes are idle.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      src1_q  <= '0;
      dst_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            src1_q <= cmd_src1;
            dst_q  <= cmd_dst;
            err_q  <= cmd_bad;
            if (!cmd_bad) addr_q <= {MEM_SEL, cmd_src0};
          end
        end
        StRd0:   addr_q <= {MEM_SEL, src1_q};
        StRd1:   op_a_q <= mem_rdata;
        StCap:   op_b_q <= mem_rdata;
        StWaitRes: begin
          if (res_valid) begin
            wdata_q <= res_data;
            addr_q  <= {MEM_SEL, dst_q};
          end
        end
        default: ;
      endcase
    end
  end

  // Moore output decode.
  always_comb begin
    cmd_ready  = 1'b0;
    mem_nRead  = 1'b1;
    mem_nWrite = 1'b1;
    op_valid   = 1'b0;
    res_ready  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    err        = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      StRd0, StRd1: mem_nRead  = 1'b0;
      StIssue:      op_valid   = 1'b1;
      StWaitRes:    res_ready  = 1'b1;
      StWr:         mem_nWrite = 1'b0;
      StDone: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;

endmodule

// File: tb/tb_matrix_operand_dma.sv
// Self-checking bench for matrix_operand_dma: memory and execution-unit models plus a
// word-level reference of main memory contents.
module tb_matrix_operand_dma;

  logic         clk, nReset;
  logic         cmd_valid, cmd_ready;
  logic [11:0]  cmd_src0, cmd_src1, cmd_dst;
  logic [15:0]  mem_addr;
  logic         mem_nRead, mem_nWrite;
  logic [255:0] mem_wdata, mem_rdata;
  logic         op_valid, op_ready;
  logic [255:0] op_a, op_b;
  logic         res_valid, res_ready;
  logic [255:0] res_data;
  logic         busy, done, err;

  matrix_operand_dma dut (
    .Clk(clk), .nReset(nReset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src0(cmd_src0), .cmd_src1(cmd_src1), .cmd_dst(cmd_dst),
    .mem_addr(mem_addr), .mem_nRead(mem_nRead), .mem_nWrite(mem_nWrite),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .err(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Main memory model and reference image.
  logic [255:0] mem     [0:15];
  logic [255:0] ref_mem [0:15];
  logic [11:0]  lat_idx;
  int rd_cnt, wr_cnt, both_low;
  int nassert, nfail;

  // Execution unit model knobs.
  int op_delay, res_delay;
  bit junk_en;
  logic [255:0] held_a, held_b;

  // Memory samples strobes on negedge; read data for a latched index appears one negedge later.
  always @(negedge clk) begin
    mem_rdata <= (lat_idx < 12'd16) ? mem[lat_idx[3:0]] : '0;
    if (!mem_nRead) lat_idx <= mem_addr[11:0];
    if (!mem_nWrite && mem_addr[15:12] == 4'h0 && mem_addr[11:0] < 12'd16)
      mem[mem_addr[3:0]] <= mem_wdata;
    if (!mem_nRead) rd_cnt <= rd_cnt + 1;
    if (!mem_nWrite) wr_cnt <= wr_cnt + 1;
    if (!mem_nRead && !mem_nWrite) both_low <= both_low + 1;
  end

  function automatic logic [255:0] lanesum(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    for (int j = 0; j < 16; j++) r[j*16 +: 16] = a[j*16 +: 16] + b[j*16 +: 16];
    return r;
  endfunction

  // Execution unit: accepts operands after op_delay cycles, returns lane sums after
  // res_delay cycles, and optionally waves junk results while not being asked.
  initial begin
    int op_wait, res_wait;
    op_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    op_wait = 0; res_wait = 0;
    forever begin
      @(negedge clk);
      if (op_valid) begin
        op_ready = (op_wait >= op_delay);
        if (op_ready) begin held_a = op_a; held_b = op_b; end
        op_wait++;
      end else begin
        op_ready = 1'b0;
        op_wait = 0;
      end
      if (res_ready) begin
        res_valid = (res_wait >= res_delay);
        res_data  = lanesum(held_a, held_b);
        res_wait++;
      end else begin
        res_valid = junk_en;
        res_data  = {8{$urandom}};
        res_wait  = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits at negedges for done, checking operands and handshake signals meanwhile.
  task automatic wait_done(input logic [255:0] ea, input logic [255:0] eb, input bit chk_ops,
                           output int cyc);
    cyc = 0;
    @(negedge clk);
    while (!done && cyc < 200) begin
      if (op_valid && chk_ops) begin
        chk("op_a", op_a, ea);
        chk("op_b", op_b, eb);
      end
      chk("cmd_ready_busy", cmd_ready, 1'b0);
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic run_cmd(input logic [11:0] s0, input logic [11:0] s1, input logic [11:0] d,
                         input int od, input int rdl, input bit junk, input bit zero_lat);
    int rd0, wr0, cyc;
    bit bad;
    logic [255:0] ea, eb;
    bad = (s0 >= 12) || (s1 >= 12) || (d >= 12);
    ea = ref_mem[s0[3:0]];
    eb = ref_mem[s1[3:0]];
    op_delay = od; res_delay = rdl; junk_en = junk;
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1'b1);
    cmd_src0 = s0; cmd_src1 = s1; cmd_dst = d; cmd_valid = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done(ea, eb, !bad, cyc);
    chk("err", err, bad);
    if (!bad) ref_mem[d[3:0]] = lanesum(ea, eb);
    if (!bad) chk("mem_dst", mem[d[3:0]], ref_mem[d[3:0]]);
    chk("read_cycles", rd_cnt - rd0, bad ? 0 : 2);
    chk("write_cycles", wr_cnt - wr0, bad ? 0 : 1);
    if (zero_lat) chk("latency", cyc, bad ? 0 : 6);
    @(negedge clk);
    chk("done_pulse", done, 1'b0);
    chk("cmd_ready_after", cmd_ready, 1'b1);
  endtask

  initial begin
    int cyc, wr0;
    logic [11:0] s0, s1, d;
    nassert = 0; nfail = 0;
    rd_cnt = 0; wr_cnt = 0; both_low = 0;
    lat_idx = '0; mem_rdata = '0;
    op_delay = 0; res_delay = 0; junk_en = 0;
    cmd_valid = 1'b0; cmd_src0 = '0; cmd_src1 = '0; cmd_dst = '0;
    for (int i = 0; i < 16; i++) mem[i] = {8{$urandom}};
    for (int j = 0; j < 16; j++) begin
      mem[0][j*16 +: 16] = 16'(16 - j);
      mem[1][j*16 +: 16] = 16'(17 + j);
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = mem[i];
    nReset = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_nRead", mem_nRead, 1'b1);
    chk("rst_nWrite", mem_nWrite, 1'b1);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_op_a", op_a, '0);
    chk("rst_op_b", op_b, '0);
    chk("rst_flags", {op_valid, res_ready, busy, done, err}, 5'b0);
    nReset = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b1);

    // Basic transfer with fixed patterns, best-case latency.
    run_cmd(12'd0, 12'd1, 12'd2, 0, 0, 0, 1);
    chk("word2_pattern", mem[2], {16{16'h0021}});

    // Execution unit stalls operand acceptance for five cycles.
    run_cmd(12'd3, 12'd4, 12'd5, 5, 2, 1, 0);

    // Rejected commands: no bus activity, done and err together.
    run_cmd(12'd0, 12'd12, 12'd2, 0, 0, 0, 1);
    run_cmd(12'd4095, 12'd1, 12'd2, 0, 0, 1, 1);
    run_cmd(12'd1, 12'd2, 12'd12, 0, 0, 0, 1);

    // Same word for both sources and destination.
    run_cmd(12'd1, 12'd1, 12'd1, 0, 0, 0, 1);

    // Reset while waiting for the result: no write reaches memory.
    op_delay = 0; res_delay = 1000; junk_en = 0;
    @(negedge clk);
    cmd_src0 = 12'd3; cmd_src1 = 12'd4; cmd_dst = 12'd5; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!res_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk("wait_res_reached", res_ready, 1'b1);
    wr0 = wr_cnt;
    nReset = 1'b0;
    #1;
    chk("arst_nRead", mem_nRead, 1'b1);
    chk("arst_nWrite", mem_nWrite, 1'b1);
    chk("arst_addr", mem_addr, 16'h0);
    chk("arst_wdata", mem_wdata, '0);
    chk("arst_op_a", op_a, '0);
    chk("arst_op_b", op_b, '0);
    chk("arst_flags", {op_valid, res_ready, busy, done, err}, 5'b0);
    @(negedge clk);
    nReset = 1'b1;
    res_delay = 0;
    repeat (3) @(negedge clk);
    chk("arst_cmd_ready", cmd_ready, 1'b1);
    chk("arst_no_write", wr_cnt - wr0, 0);
    chk("arst_mem5", mem[5], ref_mem[5]);

    // Back-to-back commands with cmd_valid held high.
    @(negedge clk);
    cmd_src0 = 12'd6; cmd_src1 = 12'd7; cmd_dst = 12'd8; cmd_valid = 1'b1;
    wait_done(ref_mem[6], ref_mem[7], 1'b1, cyc);
    chk("b2b_ready_in_done", cmd_ready, 1'b0);
    ref_mem[8] = lanesum(ref_mem[6], ref_mem[7]);
    cmd_src0 = 12'd9; cmd_src1 = 12'd10; cmd_dst = 12'd11;
    @(negedge clk);
    chk("b2b_ready_after_done", cmd_ready, 1'b1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    wait_done(ref_mem[9], ref_mem[10], 1'b1, cyc);
    chk("b2b_second_latency", cyc, 6);
    ref_mem[11] = lanesum(ref_mem[9], ref_mem[10]);
    chk("b2b_mem8", mem[8], ref_mem[8]);
    chk("b2b_mem11", mem[11], ref_mem[11]);

    // Randomized commands, occasionally out of range.
    for (int k = 0; k < 24; k++) begin
      s0 = ($urandom_range(0, 9) == 0) ? 12'(12 + $urandom_range(0, 3)) : 12'($urandom_range(0, 11));
      s1 = ($urandom_range(0, 9) == 0) ? 12'(12 + $urandom_range(0, 3)) : 12'($urandom_range(0, 11));
      d  = ($urandom_range(0, 9) == 0) ? 12'(12 + $urandom_range(0, 3)) : 12'($urandom_range(0, 11));
      run_cmd(s0, s1, d, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    end

    // Final image and strobe exclusivity.
    @(negedge clk);
    for (int i = 0; i < 12; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);
    chk("strobes_both_low", both_low, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
